// File: rtl/up_dn_cmd_gen_if.sv
// Button, switch and limit-flag inputs plus the command outputs of up_dn_cmd_gen.
// master drives buttons/switches/flags; slave is the command generator.
interface up_dn_cmd_gen_if #(
   parameter int WIDTH = 5
);
   logic             Btn_Load;
   logic             Btn_Up;
   logic             Btn_Down;
   logic [WIDTH-1:0] Sw_In;
   logic             High;
   logic             Low;
   logic [WIDTH-1:0] In;
   logic             Load;
   logic             Up;
   logic             Down;
   logic             Blocked;

   modport master (
      output Btn_Load, Btn_Up, Btn_Down, Sw_In, High, Low,
      input  In, Load, Up, Down, Blocked
   );

   modport slave (
      input  Btn_Load, Btn_Up, Btn_Down, Sw_In, High, Low,
      output In, Load, Up, Down, Blocked
   );
endinterface

// File: rtl/up_dn_cmd_gen.sv
// Debounced, arbitrated Load/Up/Down command generator for the 5-bit up/down counter.
// Define CMD_AUTO_RPT_EN to enable press-and-hold auto-repeat on Up/Down.
module up_dn_cmd_gen #(
   parameter int WIDTH   = 5,
   parameter int DEB_CYC = 4,
   parameter int RPT_DLY = 16,
   parameter int RPT_PER = 4
) (
   input  logic           Clk,
   input  logic           Rst_n,
   up_dn_cmd_gen_if.slave bus
);

   localparam int CW = $clog2(DEB_CYC + 1);

   if (DEB_CYC < 1 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_param
      $error("up_dn_cmd_gen: DEB_CYC, RPT_DLY and RPT_PER must be >= 1");
   end

   // Button index: 0 = Load, 1 = Up, 2 = Down
   logic [2:0]    w_btn;
   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_deb;
   logic [2:0]    r_press;
   logic [CW-1:0] r_cnt [3];

   assign w_btn = {bus.Btn_Down, bus.Btn_Up, bus.Btn_Load};

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_press <= '0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 3; i++) begin
            r_press[i] <= 1'b0;
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CW'(DEB_CYC - 1)) begin
               // Flip on the DEB_CYC-th mismatching cycle; a 0->1 flip is a press
               r_deb[i]   <= ~r_deb[i];
               r_cnt[i]   <= '0;
               r_press[i] <= ~r_deb[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Up/Down request FSMs, index 0 = Up, 1 = Down
`ifdef CMD_AUTO_RPT_EN
   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
   localparam int TW = $clog2(RPT_DLY) + 1;
   logic [TW-1:0] r_tmr     [2];
   logic [TW-1:0] w_tmr_nxt [2];
`else
   typedef enum logic {S_IDLE, S_HELD} state_t;
`endif

   state_t     r_st     [2];
   state_t     w_st_nxt [2];
   logic [1:0] w_req;
   logic [1:0] w_held;
   logic [1:0] w_pr;

   assign w_held = r_deb[2:1];
   assign w_pr   = r_press[2:1];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_st[i]  <= S_IDLE;
`ifdef CMD_AUTO_RPT_EN
            r_tmr[i] <= '0;
`endif
         end
      end else begin
         r_st  <= w_st_nxt;
`ifdef CMD_AUTO_RPT_EN
         r_tmr <= w_tmr_nxt;
`endif
      end
   end

   always_comb begin
      w_st_nxt  = r_st;
      w_req     = '0;
`ifdef CMD_AUTO_RPT_EN
      w_tmr_nxt = r_tmr;
`endif
      for (int i = 0; i < 2; i++) begin
         if (!w_held[i]) begin
            w_st_nxt[i] = S_IDLE;
         end else begin
`ifdef CMD_AUTO_RPT_EN
            case (r_st[i])
               S_IDLE: if (w_pr[i]) begin
                  w_req[i]     = 1'b1;
                  w_st_nxt[i]  = S_DELAY;
                  w_tmr_nxt[i] = TW'(RPT_DLY - 1);
               end
               S_DELAY, S_REPEAT: if (r_tmr[i] == '0) begin
                  w_req[i]     = 1'b1;
                  w_st_nxt[i]  = S_REPEAT;
                  w_tmr_nxt[i] = TW'(RPT_PER - 1);
               end else begin
                  w_tmr_nxt[i] = r_tmr[i] - 1'b1;
               end
               default: w_st_nxt[i] = S_IDLE;
            endcase
`else
            case (r_st[i])
               S_IDLE: if (w_pr[i]) begin
                  w_req[i]    = 1'b1;
                  w_st_nxt[i] = S_HELD;
               end
               default: w_st_nxt[i] = S_HELD;
            endcase
`endif
         end
      end
   end

   // Arbitration Load > Down > Up; losers are dropped, limits only gate Up/Down
   logic [WIDTH-1:0] r_in;
   logic             r_load;
   logic             r_up;
   logic             r_dn;
   logic             r_blk;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_in   <= '0;
         r_load <= 1'b0;
         r_up   <= 1'b0;
         r_dn   <= 1'b0;
         r_blk  <= 1'b0;
      end else begin
         r_load <= 1'b0;
         r_up   <= 1'b0;
         r_dn   <= 1'b0;
         r_blk  <= 1'b0;
         if (r_press[0]) begin
            r_load <= 1'b1;
            r_in   <= bus.Sw_In;
         end else if (w_req[1]) begin
            if (bus.Low) r_blk <= 1'b1;
            else         r_dn  <= 1'b1;
         end else if (w_req[0]) begin
            if (bus.High) r_blk <= 1'b1;
            else          r_up  <= 1'b1;
         end
      end
   end

   assign bus.In      = r_in;
   assign bus.Load    = r_load;
   assign bus.Up      = r_up;
   assign bus.Down    = r_dn;
   assign bus.Blocked = r_blk;

endmodule

// File: doc/up_dn_cmd_gen.md
Name: up_dn_cmd_gen

Overview:
- Command front-end that sits directly upstream of the 5-bit up/down counter.
- Turns raw, bouncing push-buttons and a switch bank into clean single-cycle Load/Up/Down commands plus a registered load value.
- Adds debounce, press-and-hold auto-repeat, and one-hot command arbitration.
- Reads the counter's High/Low flags so that it never issues a count beyond a limit.

Parameters:
- WIDTH, 5: width of Sw_In and In; matches the counter width.
- DEB_CYC, 4: number of consecutive cycles a synchronized button must differ from its debounced level before the new level is accepted.
- RPT_DLY, 16: cycles from the first pulse of a held Up/Down button to the first repeat pulse.
- RPT_PER, 4: cycles between subsequent repeat pulses.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  reset, asynchronous assert, active-low.
- Btn_Load  in  1  raw load button, asynchronous to Clk.
- Btn_Up  in  1  raw up button, asynchronous to Clk.
- Btn_Down  in  1  raw down button, asynchronous to Clk.
- Sw_In  in  WIDTH  raw load-value switches.
- High  in  1  counter-at-maximum flag from the counter.
- Low  in  1  counter-at-zero flag from the counter.
- In  out  WIDTH  load value to the counter; registered.
- Load  out  1  one-cycle load command.
- Up  out  1  one-cycle increment command.
- Down  out  1  one-cycle decrement command.
- Blocked  out  1  one-cycle pulse when an Up or Down command was suppressed by a limit flag.

Behaviour:
- Reset (Rst_n=0, acts immediately): In=0, Load=Up=Down=Blocked=0, all synchronizers and debounced levels =0, debounce counters =0, FSMs =IDLE.
- Synchronizer: 2-flop synchronizer on each button; Sw_In is sampled unsynchronized, only when a Load is issued.
- Debounce, per button:
  - Counter increments while synchronized value != debounced level, and clears on any cycle they match.
  - When the counter reaches DEB_CYC, the debounced level flips and the counter clears.
  - Rising edge of a debounced level = press event.
- Latency: first clock edge sampling Btn_x=1, stable thereafter = edge 1. The command output is high in the cycle following edge 3+DEB_CYC (default 7), for exactly one cycle.
- Load path:
  - Press event issues Load for one cycle; no auto-repeat.
  - In <= Sw_In on the same edge, so In is valid while Load=1.
  - In holds that value until the next Load.
- Up/Down FSM, one instance per direction:
  - States IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on press event: request pulse, timer <= RPT_DLY-1.
  - DELAY: timer decrements; at 0 -> REPEAT, request pulse, timer <= RPT_PER-1.
  - REPEAT: timer decrements; at 0, request pulse and reload RPT_PER-1.
  - Debounced release in any state -> IDLE; no pulse is emitted in that cycle.
- Arbitration, each cycle: at most one of Load/Up/Down is high.
  - Load request beats Down and Up.
  - Down beats Up, matching the counter's internal priority.
  - A losing request is dropped, not queued. FSM timing is unaffected by the loss.
- Limit gating:
  - Winning Up request while High=1: Up stays 0 and Blocked=1.
  - Winning Down request while Low=1: Down stays 0 and Blocked=1.
  - Load is never gated.
- Buttons held through reset release: the debounced level starts at 0, so a press event occurs after the normal debounce latency.
- Timers are width $clog2(RPT_DLY)+1 and never wrap. Parameters must be >=1.

Optional Feature:
- Macro CMD_AUTO_RPT_EN.
- Defined: auto-repeat as above.
- Undefined: the Up/Down FSMs reduce to IDLE/HELD, one pulse per press, no timers. RPT_DLY and RPT_PER are ignored.

Test Plan:
- Reset mid-hold: Btn_Up held, Rst_n pulsed low for 3 cycles → all outputs 0 during reset; after release exactly one Up pulse 7 edges later, counting from the first edge with Rst_n=1.
- Bounce: Btn_Up toggles every 2 cycles for 12 cycles, then stays high → exactly one Up pulse, 7 edges after the last toggle; no pulse during bouncing.
- Load capture: Sw_In=5'b01111, Btn_Load pressed → Load=1 for one cycle with In=5'b01111; Sw_In then set to 5'b00000 → In stays 5'b01111.
- Auto-repeat (macro defined): Btn_Up held 40 cycles after first pulse at t0, High=0 → Up pulses at t0, t0+16, +20, +24, +28, +32, +36, i.e. 7 pulses; macro undefined → 1 pulse.
- Priority: Btn_Up and Btn_Down pressed on the same edge → Down pulse only, Up stays 0; Btn_Load, Btn_Up and Btn_Down all pressed together → Load only.
- Limits: High=1 with Up press → Up=0, Blocked=1 for one cycle; Low=1 with Down press → Down=0, Blocked=1; Load still issued while High=1.
